// File: rtl/sram_controller_pkg.sv
// Shared definitions for the off-chip data-memory SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned MEM_BASE_DEF = 1024;
  localparam int unsigned SRAM_DW      = 16;
  localparam int unsigned SRAM_AW_DEF  = 18;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage initiator: splits 32-bit word accesses into two timed 16-bit SRAM
// accesses, stalling the pipeline through freeze until the word completes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_BASE    = MEM_BASE_DEF,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic [31:0]          alu_res,
  input  logic [31:0]          val_rm,
  output logic [31:0]          res_data,
  output logic                 ready,
  output logic                 freeze,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WW = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                wr, wr_nxt;
  logic [WW-1:0]       word, word_nxt, word_req;
  logic [31:0]         wdata, wdata_nxt;
  logic [31:0]         offset;
  logic                last;

  logic [SRAM_AW-1:0]  addr_d;
  logic [SRAM_DW-1:0]  dq_out_d;
  logic                oe_d;
  logic                we_n_d;
  logic                ready_d;

  assign offset   = alu_res - 32'(MEM_BASE);
  assign word_req = WW'(offset >> 2);
  assign last     = (cnt == CNT_LAST);
  assign freeze   = (mem_r_en | mem_w_en) & ~ready;

  // State register; address and write data are captured when a request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wr    <= 1'b0;
      word  <= '0;
      wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wr    <= wr_nxt;
      word  <= word_nxt;
      wdata <= wdata_nxt;
    end
  end

  // Next-state logic; write wins when both enables are high
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr;
    word_nxt  = word;
    wdata_nxt = wdata;
    case (state)
      ST_IDLE: begin
        if (mem_w_en || mem_r_en) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
          wr_nxt    = mem_w_en;
          word_nxt  = word_req;
          wdata_nxt = val_rm;
        end
      end
      ST_LO: begin
        if (last) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_HI: begin
        if (last) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from next state so the SRAM pins come straight off flops
  always_comb begin
    addr_d   = '0;
    dq_out_d = '0;
    oe_d     = 1'b0;
    we_n_d   = 1'b1;
    ready_d  = (state_nxt == ST_DONE);
    if (state_nxt == ST_LO || state_nxt == ST_HI) begin
      addr_d = {word_nxt, (state_nxt == ST_HI)};
      if (wr_nxt) begin
        oe_d     = 1'b1;
        dq_out_d = (state_nxt == ST_HI) ? wdata_nxt[31:16] : wdata_nxt[15:0];
        we_n_d   = (cnt_nxt == CNT_LAST);
      end
    end
  end

  // Output registers; read halves are sampled on the edge that ends each phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      ready       <= 1'b0;
      res_data    <= '0;
    end else begin
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= oe_d;
      sram_we_n   <= we_n_d;
      ready       <= ready_d;
      if (!wr && last && state == ST_LO) res_data[15:0]  <= sram_dq_in;
      if (!wr && last && state == ST_HI) res_data[31:16] <= sram_dq_in;
    end
  end

endmodule
